vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing generator, the successor to the fixed 1024x768@60 timing block. It produces the raster counters, sync and blanking signals on the `vga_if` bus that feeds the display pipeline. Every timing field and both sync polarities are parameters, and a pixel clock-enable allows slower modes from the same 65 MHz clock. It also adds line/frame start strobes and a frame counter for game-tick logic.

## Interface
Parameters:
- `H_ACTIVE`, 1024: visible pixels per line
- `H_FP`, 24: horizontal front porch (pixels)
- `H_SYNC`, 136: hsync width (pixels)
- `H_BP`, 160: horizontal back porch (pixels)
- `V_ACTIVE`, 768: visible lines
- `V_FP`, 3: vertical front porch (lines)
- `V_SYNC`, 6: vsync width (lines)
- `V_BP`, 29: vertical back porch (lines)
- `HSYNC_POL`, 0: 1 = hsync active-high, 0 = active-low
- `VSYNC_POL`, 0: 1 = vsync active-high, 0 = active-low
- `CW`, 11: width of hcount/vcount
- `FCW`, 16: width of frame_cnt

Ports:
- `clk`, in, 1: system clock, 65 MHz
- `rst`, in, 1: reset, synchronous, active-high
- `ce`, in, 1: pixel enable; the raster advances only on cycles with ce=1
- `vga_out`, vga_if.out, bundle: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
- `line_start`, out, 1: one-cycle strobe when the presented position has hcount=0
- `frame_start`, out, 1: one-cycle strobe when the presented position is (0,0)
- `frame_cnt`, out, FCW: completed-frame counter

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Elaboration `$error` if either total exceeds 2^CW or any field is 0.
- Position register (h,v): h runs 0..H_TOTAL-1, and v runs 0..V_TOTAL-1.
- On a cycle with ce=1:
  - If h = H_TOTAL-1, h is set to 0 and v advances: v = V_TOTAL-1 wraps to 0, otherwise v+1.
  - Otherwise h+1, and v holds.
- All outputs are registered and are decoded from the **next** position, so every field of vga_out describes the same pixel in the same cycle. There is no skew between counters and flags.
  - hblnk = h >= H_ACTIVE
  - vblnk = v >= V_ACTIVE
  - hsync asserted (at HSYNC_POL level) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vsync asserted (at VSYNC_POL level) for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - Deasserted sync is driven at the inverse of its POL.
  - rgb is always driven 0; downstream stages fill it.
- Strobes on a ce=1 cycle:
  - line_start = 1 when the next h = 0.
  - frame_start = 1 when the next (h,v) = (0,0); line_start is also 1 in that cycle.
  - frame_cnt increments in the same update as frame_start and wraps modulo 2^FCW.
- On a ce=0 cycle: position, counters, sync and blank outputs hold; line_start and frame_start are 0.

## Timing
- Reset values (cycle after rst sampled high): hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, rgb=0, line_start=0, frame_start=0, frame_cnt=0.
- Latency: the first ce=1 cycle after reset presents (1,0). The first frame_start occurs H_TOTAL*V_TOTAL enabled cycles after reset release.
- With ce tied high, line_start has period H_TOTAL and frame_start has period H_TOTAL*V_TOTAL. Defaults give 1344 and 1083264.
- If ce is high 1 cycle in N, every period scales by N; strobe width stays 1 clk.
- Reset mid-frame: the next cycle shows reset values regardless of ce. There is no partial-frame frame_start.
- Simultaneous rst and ce: rst wins.

## Test plan
- **Reset values.** Small config H=8/1/2/1 (total 12), V=4/1/1/1 (total 7), ce=1, hold rst 3 cycles -> all outputs at the reset values listed above, with hsync=1 and vsync=1.
- **Line timing**, small config:
  - line_start every 12 cycles.
  - hblnk=1 exactly for hcount 8..11.
  - hsync=0 exactly for hcount 9..10.
  - hcount wraps 11->0 while vcount increments in the same cycle.
- **Frame timing**, small config:
  - frame_start every 84 cycles.
  - vblnk=1 for vcount 4..6.
  - vsync low for vcount 5 only.
  - frame_cnt = 3 after 252 enabled cycles.
- **ce gating.** ce toggling 1010... -> outputs hold on ce=0 cycles, strobes stay 1 clk wide, frame_start every 168 clks.
- **Polarity and defaults.** HSYNC_POL=1, VSYNC_POL=1 -> sync idles 0 and pulses 1. Default params -> hsync for hcount 1048..1183, vsync for vcount 771..776.
- **Reset mid-frame.** Assert rst at hcount=5, vcount=2 -> next cycle (0,0); frame_cnt=0; next frame_start exactly 84 enabled cycles after release.

Source files
------------

// File: rtl/vga_if.sv
// VGA raster bus: position counters, sync/blank flags and pixel colour.
// The generator drives it through `out`/`master`; display stages read it through `in`/`slave`.
interface vga_if #(
    parameter int CW   = 11,
    parameter int RGBW = 12
);
    logic [CW-1:0]   hcount;
    logic [CW-1:0]   vcount;
    logic            hsync;
    logic            vsync;
    logic            hblnk;
    logic            vblnk;
    logic [RGBW-1:0] rgb;

    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable,
// line/frame start strobes and a completed-frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 11,
    parameter int FCW       = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    vga_if.out             vga_out,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW) ||
        H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_cfg
        $error("vga_timing_gen: zero timing field or total exceeds 2^CW");
    end

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0]  h_q, h_d, v_q, v_d;
    logic           hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic           line_q, frame_q;
    logic [FCW-1:0] fcnt_q;

    always_comb begin
        h_d = h_q + CW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
        end
    end

    // Flags are decoded from the next position so they land with the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            hblnk_q <= 1'b0;
            vblnk_q <= 1'b0;
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            if (ce) begin
                h_q     <= h_d;
                v_q     <= v_d;
                hblnk_q <= (h_d >= H_ACT);
                vblnk_q <= (v_d >= V_ACT);
                hsync_q <= (h_d >= HS_BEG && h_d < HS_END) ? HSYNC_POL : ~HSYNC_POL;
                vsync_q <= (v_d >= VS_BEG && v_d < VS_END) ? VSYNC_POL : ~VSYNC_POL;
                line_q  <= (h_d == '0);
                frame_q <= (h_d == '0) && (v_d == '0);
                if (h_d == '0 && v_d == '0) fcnt_q <= fcnt_q + FCW'(1);
            end
        end
    end

    assign vga_out.hcount = h_q;
    assign vga_out.vcount = v_q;
    assign vga_out.hsync  = hsync_q;
    assign vga_out.vsync  = vsync_q;
    assign vga_out.hblnk  = hblnk_q;
    assign vga_out.vblnk  = vblnk_q;
    assign vga_out.rgb    = '0;
    assign line_start     = line_q;
    assign frame_start    = frame_q;
    assign frame_cnt      = fcnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small, inverted-polarity, tall and default configs
// compared each cycle against a position-from-enabled-count reference model.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs, vs, hb, vb, ls, fs;
        logic [15:0] fc;
    } obs_t;

    vga_if #(.CW(11)) if_s ();
    vga_if #(.CW(11)) if_p ();
    vga_if #(.CW(11)) if_v ();
    vga_if #(.CW(11)) if_d ();
    logic        ls_s, fs_s, ls_p, fs_p, ls_v, fs_v, ls_d, fs_d;
    logic [15:0] fc_s, fc_p, fc_v, fc_d;

    vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_s (
        .clk(clk), .rst(rst), .ce(ce), .vga_out(if_s),
        .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fc_s));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) dut_p (
        .clk(clk), .rst(rst), .ce(ce), .vga_out(if_p),
        .line_start(ls_p), .frame_start(fs_p), .frame_cnt(fc_p));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1)) dut_v (
        .clk(clk), .rst(rst), .ce(ce), .vga_out(if_v),
        .line_start(ls_v), .frame_start(fs_v), .frame_cnt(fc_v));
    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .ce(ce), .vga_out(if_d),
        .line_start(ls_d), .frame_start(fs_d), .frame_cnt(fc_d));

    obs_t o_s, o_p, o_v, o_d, e_s, e_p, e_v, e_d;
    assign o_s = {if_s.hcount, if_s.vcount, if_s.hsync, if_s.vsync, if_s.hblnk, if_s.vblnk, ls_s, fs_s, fc_s};
    assign o_p = {if_p.hcount, if_p.vcount, if_p.hsync, if_p.vsync, if_p.hblnk, if_p.vblnk, ls_p, fs_p, fc_p};
    assign o_v = {if_v.hcount, if_v.vcount, if_v.hsync, if_v.vsync, if_v.hblnk, if_v.vblnk, ls_v, fs_v, fc_v};
    assign o_d = {if_d.hcount, if_d.vcount, if_d.hsync, if_d.vsync, if_d.hblnk, if_d.vblnk, ls_d, fs_d, fc_d};

    int pass_cnt = 0;
    int total    = 0;
    int n        = 0;   // enabled cycles since reset release
    bit strb     = 0;   // last clock was an enabled, non-reset update
    int cyc      = 0;

    // Position is simply the enabled-cycle count folded over the raster.
    function automatic obs_t model(int cnt, bit st, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb, bit hp, bit vp);
        obs_t m;
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int p  = cnt % (ht * vt);
        int h  = p % ht;
        int v  = p / ht;
        m.hc = 11'(h);
        m.vc = 11'(v);
        m.hb = (h >= ha);
        m.vb = (v >= va);
        m.hs = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
        m.vs = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
        m.ls = st && (h == 0);
        m.fs = st && (p == 0);
        m.fc = 16'(cnt / (ht * vt));
        return m;
    endfunction

    task automatic tick(input bit r, input bit c);
        rst = r;
        ce  = c;
        @(posedge clk);
        cyc++;
        if (r) begin n = 0; strb = 0; end
        else if (c) begin n++; strb = 1; end
        else strb = 0;
        e_s = model(n, strb, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0);
        e_p = model(n, strb, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1);
        e_v = model(n, strb, 8, 1, 2, 1, 768, 3, 6, 29, 1'b0, 1'b0);
        e_d = model(n, strb, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            total++;
            if (o_s !== e_s) $display("FAIL reset_s got %h exp %h", o_s, e_s); else pass_cnt++;
            total++;
            if (o_p !== e_p) $display("FAIL reset_p got %h exp %h", o_p, e_p); else pass_cnt++;
        end
        total++;
        if ({if_s.hsync, if_s.vsync, if_s.rgb} !== {2'b11, 12'h000})
            $display("FAIL reset_sync_rgb got %b%b %h exp 11 000", if_s.hsync, if_s.vsync, if_s.rgb);
        else pass_cnt++;
    endtask

    task automatic test_line_timing();
        int last = -1;
        for (int i = 0; i < 84; i++) begin
            tick(1'b0, 1'b1);
            total++;
            if (o_s !== e_s) $display("FAIL line_s cyc %0d got %h exp %h", cyc, o_s, e_s); else pass_cnt++;
            total++;
            if (o_p !== e_p) $display("FAIL line_p cyc %0d got %h exp %h", cyc, o_p, e_p); else pass_cnt++;
            if (ls_s) begin
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== 12) $display("FAIL line_period got %0d exp 12", cyc - last); else pass_cnt++;
                end
                last = cyc;
            end
        end
    endtask

    task automatic test_frame_timing();
        int last = -1;
        while (n < 252) begin
            tick(1'b0, 1'b1);
            total++;
            if (o_s !== e_s) $display("FAIL frame_s cyc %0d got %h exp %h", cyc, o_s, e_s); else pass_cnt++;
            if (fs_s) begin
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== 84) $display("FAIL frame_period got %0d exp 84", cyc - last); else pass_cnt++;
                end
                last = cyc;
            end
        end
        total++;
        if (fc_s !== 16'd3) $display("FAIL frame_cnt_252 got %0d exp 3", fc_s); else pass_cnt++;
    endtask

    task automatic test_ce_gating();
        obs_t prev;
        int last = -1;
        bit c = 1'b1;
        prev = o_s;
        for (int i = 0; i < 400; i++) begin
            tick(1'b0, c);
            total++;
            if (o_s !== e_s) $display("FAIL gate_s cyc %0d got %h exp %h", cyc, o_s, e_s); else pass_cnt++;
            if (!c) begin
                total++;
                if ({o_s.hc, o_s.vc, o_s.hs, o_s.vs, o_s.hb, o_s.vb, o_s.ls, o_s.fs, o_s.fc} !==
                    {prev.hc, prev.vc, prev.hs, prev.vs, prev.hb, prev.vb, 2'b00, prev.fc})
                    $display("FAIL gate_hold cyc %0d got %h prev %h", cyc, o_s, prev);
                else pass_cnt++;
            end
            if (fs_s) begin
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== 168) $display("FAIL gate_frame_period got %0d exp 168", cyc - last); else pass_cnt++;
                end
                last = cyc;
            end
            prev = o_s;
            c = !c;
        end
    endtask

    task automatic test_random_ce();
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)));
            total++;
            if (o_s !== e_s) $display("FAIL rand_s cyc %0d got %h exp %h", cyc, o_s, e_s); else pass_cnt++;
            total++;
            if (o_p !== e_p) $display("FAIL rand_p cyc %0d got %h exp %h", cyc, o_p, e_p); else pass_cnt++;
            total++;
            if (o_v !== e_v) $display("FAIL rand_v cyc %0d got %h exp %h", cyc, o_v, e_v); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int k = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (o_s.hc == 11'd5 && o_s.vc == 11'd2) found = 1;
            else tick(1'b0, 1'b1);
        end
        total++;
        if (!found) $display("FAIL midrst_reach got %0d,%0d exp 5,2", o_s.hc, o_s.vc); else pass_cnt++;
        tick(1'b1, 1'b1);
        total++;
        if (o_s !== e_s) $display("FAIL midrst_vals got %h exp %h", o_s, e_s); else pass_cnt++;
        total++;
        if ({o_s.hc, o_s.vc, o_s.fc} !== 38'd0) $display("FAIL midrst_zero got %h exp 0", {o_s.hc, o_s.vc, o_s.fc}); else pass_cnt++;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)));
            if (ce) k++;
            total++;
            if (o_s !== e_s) $display("FAIL midrst_s cyc %0d got %h exp %h", cyc, o_s, e_s); else pass_cnt++;
            if (fs_s) found = 1;
        end
        total++;
        if (!found || k !== 84) $display("FAIL midrst_first_frame got %0d enabled exp 84", k); else pass_cnt++;
    endtask

    task automatic test_defaults();
        int hs_low = 0;
        int vs_low = 0;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 9700; i++) begin
            tick(1'b0, 1'b1);
            total++;
            if (o_d !== e_d) $display("FAIL dflt_d cyc %0d got %h exp %h", cyc, o_d, e_d); else pass_cnt++;
            total++;
            if (o_v !== e_v) $display("FAIL dflt_v cyc %0d got %h exp %h", cyc, o_v, e_v); else pass_cnt++;
            if (n < 1344 && !if_d.hsync) hs_low++;
            if (n < 9672 && !if_v.vsync) vs_low++;
        end
        total++;
        if (hs_low !== 136) $display("FAIL dflt_hsync_width got %0d exp 136", hs_low); else pass_cnt++;
        total++;
        if (vs_low !== 72) $display("FAIL dflt_vsync_width got %0d exp 72", vs_low); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_ce_gating();
        test_random_ce();
        test_reset_mid();
        test_defaults();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
